irq_priority_ctrl: RTL and testbench
====================================

# irq_priority_ctrl

Sequential interrupt controller for up to NUM_IRQ request lines. It latches rising edges into a pending register and applies a software mask. It selects the highest-priority unmasked pending source (bit NUM_IRQ-1 highest, vector = index+1, 0 = none) and runs a request/acknowledge/end-of-interrupt handshake with a single consumer. It sits between the peripheral request lines and the core's interrupt entry logic and owns all pending and in-service state.

## Interface
- NUM_IRQ, 8: number of request lines.
- VEC_W, $clog2(NUM_IRQ+1) (4 at default): vector width; derived, not overridden.

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- irq  input  NUM_IRQ  level request lines, synchronous to clk
- mask_wr  input  1  write strobe for mask register
- mask_wdata  input  NUM_IRQ  new mask value (1 = masked)
- mask_q  output  NUM_IRQ  current mask register
- pending  output  NUM_IRQ  latched pending requests
- in_service  output  NUM_IRQ  one-hot source currently being serviced, 0 when none
- int_req  output  1  interrupt request to consumer
- int_vec  output  VEC_W  registered vector: candidate in REQ, serviced source in SERV, 0 in IDLE
- int_ack  input  1  consumer accepts int_vec; valid only while int_req=1
- eoi  input  1  end-of-interrupt pulse; valid only in SERV

## Operation
- Reset values: mask_q all ones, pending 0, in_service 0, int_req 0, int_vec 0, state IDLE, irq_d 0.
- Edge detect: irq_d <= irq each cycle. rise[i] = irq[i] & ~irq_d[i] sets pending[i]. An irq held high through reset release counts as an edge on the first clock.
- Masked sources still latch pending. The mask only excludes them from selection (eligible = pending & ~mask_q).
- mask_wr: mask_q <= mask_wdata at the edge. The new mask takes effect on the next cycle's selection.
- Priority encode of eligible: highest set index i gives vector i+1. If none are set, the vector is 0.
- FSM:
  - IDLE: int_req=0, int_vec=0. If eligible!=0, go to REQ and load int_vec with the encoded vector.
  - REQ: int_req=1. int_vec is reloaded every cycle from the current eligible set, so a higher-priority arrival or a mask change updates it before ack.
    - If int_ack=1: the currently registered int_vec is serviced. Set in_service to onehot(int_vec-1), clear the matching pending bit, go to SERV, and hold int_vec.
    - If eligible becomes 0 without ack: go to IDLE and set int_vec to 0.
  - SERV: int_req=0, int_vec holds the serviced vector. New edges keep accumulating in pending. No nesting or preemption. If eoi=1: clear in_service, set int_vec to 0, go to IDLE.
- Ignored inputs: int_ack outside REQ; eoi outside SERV; an int_ack and eoi in the same cycle act per the current state only.
- If a new edge on the serviced source coincides with its ack-clear, the set wins and pending stays 1.
- Reset asserted mid-operation clears all state immediately (asynchronous) regardless of state; an in-flight service is dropped.

## Timing
- irq[i] sampled high at edge k (irq_d=0): pending[i]=1 after edge k, REQ/int_req=1 after edge k+1. Latency is 2 cycles.
- int_ack sampled at edge m: int_req=0, in_service valid, pending bit cleared after edge m.
- eoi sampled at edge n: IDLE after edge n. If eligible is nonzero, REQ after edge n+1, which gives a minimum of one IDLE cycle between services.
- A mask write at edge w affects selection evaluated after edge w. A request unmasked at w raises int_req after edge w+1.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately, mask_q=0xFF; release with irq=0 -> remains IDLE.
- Basic handshake: mask_wr 0x00, pulse irq=0x04 -> pending=0x04 next edge, int_req=1 with int_vec=3 one edge later; int_ack -> in_service=0x04, pending=0x00, int_req=0; eoi -> int_vec=0, IDLE.
- Simultaneous edges: irq=0x81 in one cycle -> int_vec=8 first. After ack and eoi, one IDLE cycle, then int_vec=1.
- Late higher priority: irq[1] edge gives int_vec=2 in REQ; irq[6] edge before ack -> int_vec=7 two edges later; ack -> in_service=0x40, pending=0x02.
- Masking: mask=0x10, irq[4] edge -> pending=0x10, int_req stays 0; write mask 0x00 -> int_req=1, int_vec=5 after the next edge. Re-masking in REQ before ack -> back to IDLE, int_vec=0.
- Reset in SERV: in_service=0x08, pending=0x02, assert rst -> everything 0, mask_q=0xFF; ack/eoi pulses after release are ignored.

Source files
------------

// File: rtl/irq_priority_ctrl_if.sv
// Bus between the interrupt controller and its environment: request lines, mask port
// and the request/acknowledge/end-of-interrupt handshake with the consumer.
interface irq_priority_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  localparam int VEC_W = $clog2(NUM_IRQ + 1);

  logic [NUM_IRQ-1:0] irq;
  logic               mask_wr;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;
  logic               int_req;
  logic [VEC_W-1:0]   int_vec;
  logic               int_ack;
  logic               eoi;

  modport master (
    output irq, mask_wr, mask_wdata, int_ack, eoi,
    input  mask_q, pending, in_service, int_req, int_vec
  );

  modport slave (
    input  irq, mask_wr, mask_wdata, int_ack, eoi,
    output mask_q, pending, in_service, int_req, int_vec
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Edge-latching, maskable, fixed-priority interrupt controller with a single-consumer
// request/ack/eoi handshake. Bit NUM_IRQ-1 is the highest priority; vector = index+1.
module irq_priority_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  irq_priority_ctrl_if.slave bus
);
  localparam int VEC_W = $clog2(NUM_IRQ + 1);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t             state, state_n;
  logic [NUM_IRQ-1:0] irq_d, pending_r, mask_r, in_service_r, in_service_n;
  logic [NUM_IRQ-1:0] rise, eligible, ack_clr, vec_onehot;
  logic [VEC_W-1:0]   vec_r, vec_n, enc_vec;

  assign rise     = bus.irq & ~irq_d;
  assign eligible = pending_r & ~mask_r;

  // Ascending scan so the highest eligible index is the one left standing.
  always_comb begin
    enc_vec = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) enc_vec = VEC_W'(i + 1);
    end
  end

  always_comb begin
    vec_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      vec_onehot[i] = (vec_r == VEC_W'(i + 1));
    end
  end

  always_comb begin
    state_n      = state;
    vec_n        = vec_r;
    in_service_n = in_service_r;
    ack_clr      = '0;
    case (state)
      IDLE: begin
        if (eligible != '0) begin
          state_n = REQ;
          vec_n   = enc_vec;
        end
      end
      REQ: begin
        // The vector already presented to the consumer is what gets serviced.
        if (bus.int_ack) begin
          state_n      = SERV;
          in_service_n = vec_onehot;
          ack_clr      = vec_onehot;
        end else if (eligible == '0) begin
          state_n = IDLE;
          vec_n   = '0;
        end else begin
          vec_n = enc_vec;
        end
      end
      SERV: begin
        if (bus.eoi) begin
          state_n      = IDLE;
          in_service_n = '0;
          vec_n        = '0;
        end
      end
      default: begin
        state_n      = IDLE;
        in_service_n = '0;
        vec_n        = '0;
      end
    endcase
  end

  // A fresh edge on the source being acknowledged re-arms it: set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vec_r        <= '0;
      in_service_r <= '0;
      irq_d        <= '0;
      pending_r    <= '0;
      mask_r       <= '1;
    end else begin
      state        <= state_n;
      vec_r        <= vec_n;
      in_service_r <= in_service_n;
      irq_d        <= bus.irq;
      pending_r    <= (pending_r & ~ack_clr) | rise;
      if (bus.mask_wr) mask_r <= bus.mask_wdata;
    end
  end

  assign bus.mask_q     = mask_r;
  assign bus.pending    = pending_r;
  assign bus.in_service = in_service_r;
  assign bus.int_req    = (state == REQ);
  assign bus.int_vec    = vec_r;
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_irq_priority_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  irq_priority_ctrl_if #(.NUM_IRQ(8)) bus ();

  irq_priority_ctrl #(.NUM_IRQ(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: what the consumer should see, tracked as "requesting" / "servicing" flags.
  bit [7:0] m_pend, m_mask, m_isv, m_irqd;
  bit       m_requesting, m_servicing;
  int       m_vec;

  function automatic int top_vec(input bit [7:0] e);
    for (int i = 7; i >= 0; i--) if (e[i]) return i + 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 8'h00; m_mask = 8'hFF; m_isv = 8'h00; m_irqd = 8'h00;
      m_requesting = 1'b0; m_servicing = 1'b0; m_vec = 0;
    end else begin
      bit [7:0] rise, clr;
      int cand;
      rise = bus.irq & ~m_irqd;
      cand = top_vec(m_pend & ~m_mask);
      clr  = 8'h00;
      if (m_servicing) begin
        if (bus.eoi) begin
          m_servicing = 1'b0; m_isv = 8'h00; m_vec = 0;
        end
      end else if (m_requesting) begin
        if (bus.int_ack) begin
          m_requesting = 1'b0; m_servicing = 1'b1;
          clr   = 8'h01 << (m_vec - 1);
          m_isv = clr;
        end else if (cand == 0) begin
          m_requesting = 1'b0; m_vec = 0;
        end else begin
          m_vec = cand;
        end
      end else if (cand != 0) begin
        m_requesting = 1'b1; m_vec = cand;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (bus.mask_wr) m_mask = bus.mask_wdata;
      m_irqd = bus.irq;
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("model pending",    int'(bus.pending),    int'(m_pend));
    cmp("model mask_q",     int'(bus.mask_q),     int'(m_mask));
    cmp("model in_service", int'(bus.in_service), int'(m_isv));
    cmp("model int_req",    int'(bus.int_req),    int'(m_requesting));
    cmp("model int_vec",    int'(bus.int_vec),    m_vec);
  end

  task automatic applyStimulus(input bit [7:0] irq, input bit ack, input bit eoi,
                               input bit mwr = 1'b0, input bit [7:0] mdata = 8'h00);
    bus.irq = irq; bus.int_ack = ack; bus.eoi = eoi;
    bus.mask_wr = mwr; bus.mask_wdata = mdata;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input bit [7:0] pend, input bit [7:0] isv,
                             input bit req, input int vec, input bit [7:0] mask);
    cmp({name, " pending"},    int'(bus.pending),    int'(pend));
    cmp({name, " in_service"}, int'(bus.in_service), int'(isv));
    cmp({name, " int_req"},    int'(bus.int_req),    int'(req));
    cmp({name, " int_vec"},    int'(bus.int_vec),    vec);
    cmp({name, " mask_q"},     int'(bus.mask_q),     int'(mask));
  endtask

  initial begin
    rst = 1'b1;
    bus.irq = '0; bus.int_ack = 1'b0; bus.eoi = 1'b0;
    bus.mask_wr = 1'b0; bus.mask_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset", 8'h00, 8'h00, 1'b0, 0, 8'hFF);
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("post-reset idle", 8'h00, 8'h00, 1'b0, 0, 8'hFF);

    // Basic handshake
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(8'h04, 1'b0, 1'b0);
    checkOutput("basic pend", 8'h04, 8'h00, 1'b0, 0, 8'h00);
    applyStimulus(8'h04, 1'b0, 1'b0);
    checkOutput("basic req", 8'h04, 8'h00, 1'b1, 3, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("eoi ignored in req", 8'h04, 8'h00, 1'b1, 3, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("basic ack", 8'h00, 8'h04, 1'b0, 3, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("ack ignored in serv", 8'h00, 8'h04, 1'b0, 3, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("basic eoi", 8'h00, 8'h00, 1'b0, 0, 8'h00);

    // Simultaneous edges: highest first, one IDLE cycle between services
    applyStimulus(8'h81, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("simul req8", 8'h81, 8'h00, 1'b1, 8, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("simul ack8", 8'h01, 8'h80, 1'b0, 8, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("simul idle gap", 8'h01, 8'h00, 1'b0, 0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("simul req1", 8'h01, 8'h00, 1'b1, 1, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1);

    // Late higher-priority arrival updates the vector before ack
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("late req2", 8'h02, 8'h00, 1'b1, 2, 8'h00);
    applyStimulus(8'h40, 1'b0, 1'b0);
    checkOutput("late still2", 8'h42, 8'h00, 1'b1, 2, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("late req7", 8'h42, 8'h00, 1'b1, 7, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("late ack7", 8'h02, 8'h40, 1'b0, 7, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("late drained", 8'h00, 8'h00, 1'b0, 0, 8'h00);

    // Masking: masked sources latch but are not selected
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'h10);
    applyStimulus(8'h10, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("masked pend", 8'h10, 8'h00, 1'b0, 0, 8'h10);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("unmask edge", 8'h10, 8'h00, 1'b0, 0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("unmask req5", 8'h10, 8'h00, 1'b1, 5, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'h10);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("remask idle", 8'h10, 8'h00, 1'b0, 0, 8'h10);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1);

    // New edge on the acked source: set wins over clear
    applyStimulus(8'h08, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b1, 1'b0);
    checkOutput("set wins", 8'h08, 8'h08, 1'b0, 4, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1);

    // Reset while in service
    applyStimulus(8'h08, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    checkOutput("serv before rst", 8'h02, 8'h08, 1'b0, 4, 8'h00);
    bus.irq = 8'h00; bus.int_ack = 1'b0;
    #2 rst = 1'b1;
    #1 checkOutput("async rst", 8'h00, 8'h00, 1'b0, 0, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("after rst ignored", 8'h00, 8'h00, 1'b0, 0, 8'hFF);

    // irq held through reset release counts as an edge (mask still all ones)
    bus.irq = 8'h01;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h01, 1'b0, 1'b0);
    checkOutput("held through rst", 8'h01, 8'h00, 1'b0, 0, 8'hFF);
    applyStimulus(8'h01, 1'b0, 1'b0);
    checkOutput("masked no req", 8'h01, 8'h00, 1'b0, 0, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
